// File: rtl/rca_seq_pkg.sv
// Shared types and defaults for the multi-precision add sequencer.
//   state_t        : sequencer FSM states (IDLE, RUN, DONE)
//   DEF_SLICE_W    : default width of the combinational adder slice
//   DEF_NUM_SLICES : default number of slices per operation
//   full_add()     : one full-adder cell, returns {carry_out, sum}
package rca_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_SLICE_W    = 8;
    localparam int unsigned DEF_NUM_SLICES = 4;

    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s;
        logic co;
        s  = a ^ b ^ c;
        co = (a & b) | (c & (a ^ b));
        return {co, s};
    endfunction

endpackage

// File: rtl/rca_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from full-adder cells.
// Ports:
//   a, b  in  SLICE_W  addends
//   cin   in  1        carry into bit 0
//   sum   out SLICE_W  a + b + cin (low SLICE_W bits)
//   cout  out 1        carry out of the top bit
module rca_slice
    import rca_seq_pkg::*;
#(
    parameter int unsigned SLICE_W = DEF_SLICE_W
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W:0] carry;
    logic [1:0]       fa;

    always_comb begin
        carry    = '0;
        sum      = '0;
        fa       = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < SLICE_W; i++) begin
            fa         = full_add(a[i], b[i], carry[i]);
            sum[i]     = fa[0];
            carry[i+1] = fa[1];
        end
        cout = carry[SLICE_W];
    end

endmodule

// File: rtl/rca_mp_sequencer.sv
// Multi-precision add sequencer: one W-bit add (W = SLICE_W*NUM_SLICES) performed
// by a single SLICE_W-bit ripple-carry slice, one slice per clock, LS slice first,
// with the carry registered between slices.
// Optional feature: define RCA_SEQ_SUB_EN to add the op_sub port (subtract a - b).
// Ports:
//   clk        in   1  rising-edge clock
//   rst_n      in   1  asynchronous active-low reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  idle, can accept operands
//   op_a/op_b  in   W  operands
//   op_cin     in   1  carry into slice 0
//   op_sub     in   1  subtract request (RCA_SEQ_SUB_EN only)
//   out_valid  out  1  result valid, held until out_ready
//   out_ready  in   1  consumer accepts result
//   result     out  W  registered sum / difference
//   cout       out  1  registered carry out of the top slice
//   busy       out  1  operation in progress or result pending
module rca_mp_sequencer
    import rca_seq_pkg::*;
#(
    parameter int unsigned SLICE_W    = DEF_SLICE_W,
    parameter int unsigned NUM_SLICES = DEF_NUM_SLICES
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_a,
    input  logic [SLICE_W*NUM_SLICES-1:0] op_b,
    input  logic                          op_cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic                          op_sub,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [SLICE_W*NUM_SLICES-1:0] result,
    output logic                          cout,
    output logic                          busy
);

    localparam int unsigned W     = SLICE_W * NUM_SLICES;
    localparam int unsigned IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [IDX_W-1:0]   slice_idx;
    logic               carry_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       result_q;
    logic               cout_q;
    logic               accept;
    logic               init_carry;
    logic [W-1:0]       b_eff;
    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W-1:0] sl_sum;
    logic               sl_cout;

    assign accept = in_valid && (state_q == IDLE);

`ifdef RCA_SEQ_SUB_EN
    logic sub_q;
    // Subtraction as a + ~b + 1: invert B per slice, force carry-in to 1.
    assign init_carry = op_sub ? 1'b1 : op_cin;
    assign b_eff      = sub_q ? ~b_q : b_q;
`else
    assign init_carry = op_cin;
    assign b_eff      = b_q;
`endif

    // Select the operand slice addressed by slice_idx.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int unsigned k = 0; k < NUM_SLICES; k++) begin
            if (slice_idx == IDX_W'(k)) begin
                a_sl = a_q[k*SLICE_W +: SLICE_W];
                b_sl = b_eff[k*SLICE_W +: SLICE_W];
            end
        end
    end

    rca_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry_q),
        .sum  (sl_sum),
        .cout (sl_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (slice_idx == LAST_IDX) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slice_idx <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            cout_q    <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            sub_q     <= 1'b0;
`endif
        end else if (accept) begin
            a_q       <= op_a;
            b_q       <= op_b;
            slice_idx <= '0;
            carry_q   <= init_carry;
`ifdef RCA_SEQ_SUB_EN
            sub_q     <= op_sub;
`endif
        end else if (state_q == RUN) begin
            for (int unsigned k = 0; k < NUM_SLICES; k++) begin
                if (slice_idx == IDX_W'(k)) begin
                    result_q[k*SLICE_W +: SLICE_W] <= sl_sum;
                end
            end
            carry_q <= sl_cout;
            // Index parks on the last slice so it never exceeds NUM_SLICES-1.
            if (slice_idx == LAST_IDX) begin
                cout_q <= sl_cout;
            end else begin
                slice_idx <= slice_idx + 1'b1;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign result    = result_q;
    assign cout      = cout_q;

endmodule
